control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide parameter DEVICE_ADDR, default 8'h10, the unit address this block responds to.
REQ-002 SHALL provide parameter INIT_STATUS, default 8'h00, the initial-status byte presented after command accept.
REQ-003 SHALL have ports (channel-side inputs are already synchronous to aclk):
  aclk  in  1  clock, all logic on rising edge
  aresetn  in  1  asynchronous active-low reset
  enable  in  1  block participates in selection when high
  a_bus_out / a_bus_out_parity  in  8/1  channel-to-unit bus, odd parity
  a_bus_in / a_bus_in_parity  out  8/1  unit-to-channel bus, odd parity
  a_operational_out, a_select_out, a_hold_out, a_address_out, a_command_out, a_service_out, a_suppress_out  in  1 each  channel tags
  a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in  out  1 each  unit tags
  cmd_tdata / cmd_tvalid  out  8/1  accepted command byte, 1-cycle pulse
  recv_tdata / recv_tvalid / recv_tready  out/out/in  8/1/1  bytes received from channel (write commands)
  send_tdata / send_tvalid / send_tready  in/in/out  8/1/1  bytes sent to channel (read commands)
  end_tdata / end_tvalid / end_tready  in/in/out  8/1/1  host-supplied ending status
  busy  out  1  high whenever state != IDLE
  parity_error  out  1  sticky, set on bad a_bus_out parity in any capture

Function
REQ-004 States: IDLE, OPL, ADDR_IN, CMD_WAIT, INIT_ST, DATA, XFER, END_ST, DISC.
REQ-005 IDLE: a_select_in SHALL equal a_select_out registered (1-cycle pass-through); all other unit tags low; a_bus_in = 0.
REQ-006 IDLE -> OPL when enable && a_operational_out && a_select_out && a_hold_out && a_address_out && a_bus_out==DEVICE_ADDR; a_select_in SHALL then stay low (selection not propagated).
REQ-007 OPL: assert a_operational_in; next cycle -> ADDR_IN.
REQ-008 ADDR_IN: a_address_in=1, a_bus_in=DEVICE_ADDR; on a_command_out high capture a_bus_out, pulse cmd_tvalid, drop a_address_in -> CMD_WAIT.
REQ-009 CMD_WAIT: on a_command_out low -> INIT_ST.
REQ-010 INIT_ST: a_status_in=1, a_bus_in=INIT_STATUS; on a_service_out -> drop a_status_in, wait a_service_out low -> DATA; on a_command_out (stack) -> DISC.
REQ-011 DATA, write command (cmd bit0=1): raise a_service_in; on a_service_out capture a_bus_out to recv_tdata, recv_tvalid=1, drop a_service_in -> XFER.
REQ-012 DATA, read command (bit0=0): when send_tvalid, drive send_tdata on a_bus_in, send_tready 1-cycle pulse, raise a_service_in; on a_service_out drop a_service_in -> XFER.
REQ-013 XFER: wait a_service_out low and (write) recv_tvalid&&recv_tready handshake complete -> DATA; recv_tvalid SHALL hold with stable data until accepted.
REQ-014 In DATA, a_command_out in place of a_service_out (channel stop) SHALL drop a_service_in, discard any pending byte, load status 8'h0C -> END_ST.
REQ-015 In DATA with no a_service_in raised, end_tvalid SHALL pulse end_tready, load end_tdata -> END_ST; channel stop wins if both same cycle.
REQ-016 END_ST: a_status_in=1 with status on a_bus_in; on a_service_out drop a_status_in -> DISC.
REQ-017 DISC: drop a_operational_in once a_service_out and a_command_out are low -> IDLE.
REQ-018 a_bus_in_parity SHALL always equal ~^a_bus_in; a_request_in SHALL stay 0 (no unsolicited status).
REQ-019 a_operational_out low in any state SHALL return to IDLE next cycle with all unit tags low (selective reset); a_suppress_out is ignored.
REQ-020 At most one of a_address_in, a_status_in, a_service_in SHALL be high in any cycle.

Reset
REQ-021 aresetn low SHALL asynchronously force IDLE, all outputs 0 (a_bus_in=0, a_bus_in_parity=1, cmd_tvalid=recv_tvalid=send_tready=end_tready=busy=parity_error=0).
REQ-022 Reset mid-transfer SHALL abandon the operation with no further handshake pulses.

Verification
REQ-023 Select with a_bus_out=8'h10 -> a_operational_in, a_address_in with a_bus_in=8'h10; command 8'h01 -> cmd_tvalid pulse, cmd_tdata=8'h01, status 8'h00.
REQ-024 Select with a_bus_out=8'h22 -> a_select_in follows a_select_out one cycle later, a_operational_in stays 0.
REQ-025 Write command, channel sends 8'hA5,8'h5A with recv_tready held low 5 cycles -> two recv beats in order, second a_service_in only after first accepted.
REQ-026 Read command, host sends 8'h01,8'h02 then end_tdata=8'h0C -> two service cycles with a_bus_in=8'h01,8'h02, parity 0,0, then status 8'h0C, disconnect to IDLE.
REQ-027 Channel stop after one byte -> status 8'h0C presented; a_operational_out dropped mid-DATA -> IDLE next cycle, all tags low.
REQ-028 Bad parity on command byte -> parity_error=1 and remains 1 until aresetn.

Source files
------------

// File: rtl/control_unit.sv
// Channel-side control unit: selection, command accept, byte transfer
// between channel tags and stream ports, ending status and disconnect.
module control_unit #(
  parameter logic [7:0] DEVICE_ADDR = 8'h10,
  parameter logic [7:0] INIT_STATUS = 8'h00
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic [7:0] a_bus_out,
  input  logic       a_bus_out_parity,
  output logic [7:0] a_bus_in,
  output logic       a_bus_in_parity,
  input  logic       a_operational_out,
  input  logic       a_select_out,
  input  logic       a_hold_out,
  input  logic       a_address_out,
  input  logic       a_command_out,
  input  logic       a_service_out,
  input  logic       a_suppress_out,
  output logic       a_operational_in,
  output logic       a_select_in,
  output logic       a_address_in,
  output logic       a_status_in,
  output logic       a_service_in,
  output logic       a_request_in,
  output logic [7:0] cmd_tdata,
  output logic       cmd_tvalid,
  output logic [7:0] recv_tdata,
  output logic       recv_tvalid,
  input  logic       recv_tready,
  input  logic [7:0] send_tdata,
  input  logic       send_tvalid,
  output logic       send_tready,
  input  logic [7:0] end_tdata,
  input  logic       end_tvalid,
  output logic       end_tready,
  output logic       busy,
  output logic       parity_error
);

  typedef enum logic [3:0] {
    IDLE, OPL, ADDR_IN, CMD_WAIT, INIT_ST,
    DATA, XFER, END_ST, DISC
  } state_t;

  state_t state;
  logic   cmd_write;
  logic   init_done;
  logic   par_ok;
  logic   sel_hit;
  logic   unused_suppress;

  assign par_ok = ^{a_bus_out, a_bus_out_parity};
  assign sel_hit = enable && a_operational_out && a_select_out
                && a_hold_out && a_address_out
                && (a_bus_out == DEVICE_ADDR);
  assign a_bus_in_parity = ~^a_bus_in;
  assign a_request_in = 1'b0;
  assign busy = (state != IDLE);
  assign unused_suppress = a_suppress_out;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      cmd_write        <= 1'b0;
      init_done        <= 1'b0;
      a_bus_in         <= 8'h00;
      a_operational_in <= 1'b0;
      a_select_in      <= 1'b0;
      a_address_in     <= 1'b0;
      a_status_in      <= 1'b0;
      a_service_in     <= 1'b0;
      cmd_tdata        <= 8'h00;
      cmd_tvalid       <= 1'b0;
      recv_tdata       <= 8'h00;
      recv_tvalid      <= 1'b0;
      send_tready      <= 1'b0;
      end_tready       <= 1'b0;
      parity_error     <= 1'b0;
    end else begin
      cmd_tvalid  <= 1'b0;
      send_tready <= 1'b0;
      end_tready  <= 1'b0;
      if (recv_tvalid && recv_tready)
        recv_tvalid <= 1'b0;
      // selective reset: channel dropped operational out
      if (state != IDLE && !a_operational_out) begin
        state            <= IDLE;
        init_done        <= 1'b0;
        a_bus_in         <= 8'h00;
        a_operational_in <= 1'b0;
        a_select_in      <= 1'b0;
        a_address_in     <= 1'b0;
        a_status_in      <= 1'b0;
        a_service_in     <= 1'b0;
        recv_tvalid      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            a_select_in <= a_select_out;
            a_bus_in    <= 8'h00;
            if (sel_hit) begin
              a_select_in      <= 1'b0;
              a_operational_in <= 1'b1;
              state            <= OPL;
              if (!par_ok) parity_error <= 1'b1;
            end
          end
          OPL: begin
            a_address_in <= 1'b1;
            a_bus_in     <= DEVICE_ADDR;
            state        <= ADDR_IN;
          end
          ADDR_IN: begin
            if (a_command_out) begin
              cmd_tdata    <= a_bus_out;
              cmd_tvalid   <= 1'b1;
              cmd_write    <= a_bus_out[0];
              a_address_in <= 1'b0;
              a_bus_in     <= 8'h00;
              state        <= CMD_WAIT;
              if (!par_ok) parity_error <= 1'b1;
            end
          end
          CMD_WAIT: begin
            if (!a_command_out) begin
              a_status_in <= 1'b1;
              a_bus_in    <= INIT_STATUS;
              init_done   <= 1'b0;
              state       <= INIT_ST;
            end
          end
          INIT_ST: begin
            if (!init_done) begin
              if (a_command_out) begin
                a_status_in <= 1'b0;
                a_bus_in    <= 8'h00;
                state       <= DISC;
              end else if (a_service_out) begin
                a_status_in <= 1'b0;
                a_bus_in    <= 8'h00;
                init_done   <= 1'b1;
              end
            end else if (!a_service_out) begin
              init_done <= 1'b0;
              state     <= DATA;
            end
          end
          DATA: begin
            if (a_command_out) begin
              a_service_in <= 1'b0;
              a_status_in  <= 1'b1;
              a_bus_in     <= 8'h0C;
              state        <= END_ST;
            end else if (a_service_in) begin
              if (a_service_out) begin
                if (cmd_write) begin
                  recv_tdata  <= a_bus_out;
                  recv_tvalid <= 1'b1;
                  if (!par_ok) parity_error <= 1'b1;
                end
                a_service_in <= 1'b0;
                a_bus_in     <= 8'h00;
                state        <= XFER;
              end
            end else if (end_tvalid) begin
              end_tready  <= 1'b1;
              a_status_in <= 1'b1;
              a_bus_in    <= end_tdata;
              state       <= END_ST;
            end else if (cmd_write) begin
              a_service_in <= 1'b1;
            end else if (send_tvalid) begin
              send_tready  <= 1'b1;
              a_bus_in     <= send_tdata;
              a_service_in <= 1'b1;
            end
          end
          XFER: begin
            if (!a_service_out && (!recv_tvalid || recv_tready))
              state <= DATA;
          end
          END_ST: begin
            if (a_service_out) begin
              a_status_in <= 1'b0;
              a_bus_in    <= 8'h00;
              state       <= DISC;
            end
          end
          DISC: begin
            if (!a_service_out && !a_command_out) begin
              a_operational_in <= 1'b0;
              state            <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scenario bench for control_unit: selection, command, write/read
// transfers, channel stop, selective reset, parity and async reset.
module tb_control_unit;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] a_bus_out = 8'h00;
  logic       a_bus_out_parity = 1'b1;
  logic [7:0] a_bus_in;
  logic       a_bus_in_parity;
  logic       a_operational_out = 1'b0;
  logic       a_select_out = 1'b0;
  logic       a_hold_out = 1'b0;
  logic       a_address_out = 1'b0;
  logic       a_command_out = 1'b0;
  logic       a_service_out = 1'b0;
  logic       a_suppress_out = 1'b0;
  logic       a_operational_in;
  logic       a_select_in;
  logic       a_address_in;
  logic       a_status_in;
  logic       a_service_in;
  logic       a_request_in;
  logic [7:0] cmd_tdata;
  logic       cmd_tvalid;
  logic [7:0] recv_tdata;
  logic       recv_tvalid;
  logic       recv_tready = 1'b0;
  logic [7:0] send_tdata = 8'h00;
  logic       send_tvalid = 1'b0;
  logic       send_tready;
  logic [7:0] end_tdata = 8'h00;
  logic       end_tvalid = 1'b0;
  logic       end_tready;
  logic       busy;
  logic       parity_error;

  int checks = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  control_unit #(.DEVICE_ADDR(8'h10), .INIT_STATUS(8'h00)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
    .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
    .a_operational_out(a_operational_out), .a_select_out(a_select_out),
    .a_hold_out(a_hold_out), .a_address_out(a_address_out),
    .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out),
    .a_operational_in(a_operational_in), .a_select_in(a_select_in),
    .a_address_in(a_address_in), .a_status_in(a_status_in),
    .a_service_in(a_service_in), .a_request_in(a_request_in),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
    .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid),
    .recv_tready(recv_tready),
    .send_tdata(send_tdata), .send_tvalid(send_tvalid),
    .send_tready(send_tready),
    .end_tdata(end_tdata), .end_tvalid(end_tvalid),
    .end_tready(end_tready),
    .busy(busy), .parity_error(parity_error)
  );

  always #5 aclk = ~aclk;

  function automatic logic odd(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [5:0] tags();
    return {a_operational_in, a_select_in, a_address_in,
            a_status_in, a_service_in, a_request_in};
  endfunction

  function automatic logic cond(input int s);
    case (s)
      0: return a_operational_in;
      1: return a_address_in;
      2: return a_status_in;
      3: return !a_status_in;
      4: return a_service_in;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic put_bus(input logic [7:0] b, input logic bad);
    a_bus_out = b;
    a_bus_out_parity = odd(b) ^ bad;
  endtask

  task automatic chan_idle();
    a_select_out = 0; a_hold_out = 0; a_address_out = 0;
    a_command_out = 0; a_service_out = 0; a_suppress_out = 0;
    put_bus(8'h00, 1'b0);
  endtask

  task automatic wait_for(input int s, input string nm);
    int n;
    n = 0;
    while (!cond(s) && n < 100) begin
      tick();
      n++;
    end
    if (!cond(s)) begin
      checks++; errs++;
      $display("FAIL timeout_%s: got 0 expected 1 within 100 cycles", nm);
    end
  endtask

  // drive selection, command and initial-status exchange up to DATA
  task automatic connect(input logic [7:0] cmd, input logic bad);
    a_operational_out = 1; a_select_out = 1; a_hold_out = 1;
    a_address_out = 1; put_bus(8'h10, 1'b0);
    tick();
    wait_for(0, "select");
    a_select_out = 0; a_hold_out = 0; a_address_out = 0;
    put_bus(8'h00, 1'b0);
    wait_for(1, "address_in");
    a_command_out = 1; put_bus(cmd, bad);
    tick();
    a_command_out = 0; put_bus(8'h00, 1'b0);
    wait_for(2, "init_status");
    a_service_out = 1;
    tick();
    wait_for(3, "init_status_drop");
    a_service_out = 0;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 0;
    chan_idle();
    tick(); tick();
    checks++;
    if (tags() !== 6'b0) begin
      errs++; $display("FAIL reset_tags: got %b expected %b", tags(), 6'b0);
    end
    checks++;
    if ({a_bus_in, a_bus_in_parity} !== 9'h001) begin
      errs++; $display("FAIL reset_bus: got %h expected %h",
                       {a_bus_in, a_bus_in_parity}, 9'h001);
    end
    checks++;
    if ({cmd_tvalid, recv_tvalid, send_tready, end_tready, busy,
         parity_error} !== 6'b0) begin
      errs++; $display("FAIL reset_flags: got %b expected %b",
        {cmd_tvalid, recv_tvalid, send_tready, end_tready, busy,
         parity_error}, 6'b0);
    end
    aresetn = 1; enable = 1; a_operational_out = 1;
    tick();
  endtask

  task automatic test_select_cmd();
    a_select_out = 1; a_hold_out = 1; a_address_out = 1;
    put_bus(8'h10, 1'b0);
    tick();
    checks++;
    if ({a_operational_in, a_select_in} !== 2'b10) begin
      errs++; $display("FAIL select_opl: got %b expected %b",
                       {a_operational_in, a_select_in}, 2'b10);
    end
    a_select_out = 0; a_hold_out = 0; a_address_out = 0;
    put_bus(8'h00, 1'b0);
    tick();
    checks++;
    if ({a_address_in, a_bus_in} !== {1'b1, 8'h10}) begin
      errs++; $display("FAIL address_in: got %h expected %h",
                       {a_address_in, a_bus_in}, {1'b1, 8'h10});
    end
    a_command_out = 1; put_bus(8'h01, 1'b0);
    exp_q.push_back(8'h01);
    tick();
    checks++;
    if ({cmd_tvalid, a_address_in, cmd_tdata} !== {2'b10, exp_q[0]}) begin
      errs++; $display("FAIL cmd_accept: got %h expected %h",
        {cmd_tvalid, a_address_in, cmd_tdata}, {2'b10, exp_q[0]});
    end
    void'(exp_q.pop_front());
    a_command_out = 0; put_bus(8'h00, 1'b0);
    tick();
    checks++;
    if ({a_status_in, a_bus_in, a_bus_in_parity} !== {1'b1, 8'h00, 1'b1}) begin
      errs++; $display("FAIL init_status: got %h expected %h",
        {a_status_in, a_bus_in, a_bus_in_parity}, {1'b1, 8'h00, 1'b1});
    end
    checks++;
    if (cmd_tvalid !== 1'b0) begin
      errs++; $display("FAIL cmd_pulse: got %b expected 0", cmd_tvalid);
    end
    a_service_out = 1; tick();
    a_service_out = 0; tick();
    tick();
    checks++;
    if ({a_address_in, a_status_in, a_service_in} !== 3'b001) begin
      errs++; $display("FAIL write_svc: got %b expected %b",
        {a_address_in, a_status_in, a_service_in}, 3'b001);
    end
    a_operational_out = 0;
    tick();
    checks++;
    if ({tags(), busy} !== 7'b0) begin
      errs++; $display("FAIL sel_reset_init: got %b expected %b",
                       {tags(), busy}, 7'b0);
    end
    a_operational_out = 1;
    tick();
  endtask

  task automatic test_no_select();
    a_select_out = 1; a_hold_out = 1; a_address_out = 1;
    put_bus(8'h22, 1'b0);
    checks++;
    if (a_select_in !== 1'b0) begin
      errs++; $display("FAIL sel_pass_pre: got %b expected 0", a_select_in);
    end
    tick();
    checks++;
    if ({a_select_in, a_operational_in, busy} !== 3'b100) begin
      errs++; $display("FAIL sel_pass: got %b expected %b",
        {a_select_in, a_operational_in, busy}, 3'b100);
    end
    a_select_out = 0;
    tick();
    checks++;
    if (a_select_in !== 1'b0) begin
      errs++; $display("FAIL sel_pass_drop: got %b expected 0", a_select_in);
    end
    enable = 0; a_select_out = 1; put_bus(8'h10, 1'b0);
    tick();
    checks++;
    if ({a_select_in, a_operational_in, busy} !== 3'b100) begin
      errs++; $display("FAIL disabled_sel: got %b expected %b",
        {a_select_in, a_operational_in, busy}, 3'b100);
    end
    chan_idle(); enable = 1;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] bytes [2];
    logic [7:0] e;
    bytes[0] = 8'hA5; bytes[1] = 8'h5A;
    connect(8'h01, 1'b0);
    recv_tready = 0;
    for (int i = 0; i < 2; i++) begin
      wait_for(4, "write_svc");
      checks++;
      if ({a_address_in, a_status_in} !== 2'b00) begin
        errs++; $display("FAIL one_tag: got %b expected 00",
                         {a_address_in, a_status_in});
      end
      a_service_out = 1; put_bus(bytes[i], 1'b0);
      exp_q.push_back(bytes[i]);
      tick();
      a_service_out = 0; put_bus(8'h00, 1'b0);
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({a_service_in, recv_tvalid, recv_tdata} !== {2'b01, bytes[i]}) begin
          errs++; $display("FAIL recv_stall: got %h expected %h",
            {a_service_in, recv_tvalid, recv_tdata}, {2'b01, bytes[i]});
        end
        tick();
      end
      recv_tready = 1;
      e = exp_q.pop_front();
      checks++;
      if ({recv_tvalid, recv_tdata} !== {1'b1, e}) begin
        errs++; $display("FAIL recv_beat: got %h expected %h",
                         {recv_tvalid, recv_tdata}, {1'b1, e});
      end
      tick();
      recv_tready = 0;
    end
    end_tvalid = 1; end_tdata = 8'h00;
    tick();
    end_tvalid = 0;
    checks++;
    if ({end_tready, a_status_in, a_service_in, a_bus_in} !== {3'b110, 8'h00}) begin
      errs++; $display("FAIL write_end: got %h expected %h",
        {end_tready, a_status_in, a_service_in, a_bus_in}, {3'b110, 8'h00});
    end
    a_service_out = 1; tick();
    a_service_out = 0; tick();
    checks++;
    if ({busy, a_operational_in} !== 2'b00) begin
      errs++; $display("FAIL write_disc: got %b expected 00",
                       {busy, a_operational_in});
    end
  endtask

  task automatic test_read();
    logic [7:0] e;
    connect(8'h02, 1'b0);
    send_tdata = 8'h01; send_tvalid = 1;
    exp_q.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      wait_for(4, "read_svc");
      e = exp_q.pop_front();
      checks++;
      if ({send_tready, a_bus_in, a_bus_in_parity} !== {1'b1, e, odd(e)}) begin
        errs++; $display("FAIL read_beat: got %h expected %h",
          {send_tready, a_bus_in, a_bus_in_parity}, {1'b1, e, odd(e)});
      end
      if (i == 0) begin
        send_tdata = 8'h02;
        exp_q.push_back(8'h02);
      end else begin
        send_tvalid = 0;
      end
      a_service_out = 1; tick();
      a_service_out = 0;
    end
    end_tvalid = 1; end_tdata = 8'h0C;
    exp_q.push_back(8'h0C);
    wait_for(2, "read_end");
    end_tvalid = 0;
    e = exp_q.pop_front();
    checks++;
    if ({end_tready, a_bus_in} !== {1'b1, e}) begin
      errs++; $display("FAIL read_end: got %h expected %h",
                       {end_tready, a_bus_in}, {1'b1, e});
    end
    a_service_out = 1; tick();
    a_service_out = 0; tick();
    checks++;
    if ({busy, a_operational_in, exp_q.size() == 0} !== 3'b001) begin
      errs++; $display("FAIL read_disc: got %b expected 001",
        {busy, a_operational_in, exp_q.size() == 0});
    end
  endtask

  task automatic test_stop();
    logic [7:0] e;
    connect(8'h01, 1'b0);
    wait_for(4, "stop_svc");
    a_service_out = 1; put_bus(8'h33, 1'b0);
    exp_q.push_back(8'h33);
    tick();
    a_service_out = 0; put_bus(8'h00, 1'b0);
    recv_tready = 1;
    e = exp_q.pop_front();
    checks++;
    if ({recv_tvalid, recv_tdata} !== {1'b1, e}) begin
      errs++; $display("FAIL stop_beat: got %h expected %h",
                       {recv_tvalid, recv_tdata}, {1'b1, e});
    end
    tick();
    recv_tready = 0;
    wait_for(4, "stop_svc2");
    a_command_out = 1;
    exp_q.push_back(8'h0C);
    tick();
    a_command_out = 0;
    e = exp_q.pop_front();
    checks++;
    if ({a_status_in, a_service_in, a_bus_in} !== {2'b10, e}) begin
      errs++; $display("FAIL stop_status: got %h expected %h",
                       {a_status_in, a_service_in, a_bus_in}, {2'b10, e});
    end
    a_service_out = 1; tick();
    a_service_out = 0; tick();
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL stop_disc: got %b expected 0", busy);
    end
  endtask

  task automatic test_selective_reset();
    connect(8'h02, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL data_busy: got %b expected 1", busy);
    end
    a_operational_out = 0;
    tick();
    checks++;
    if ({tags(), busy} !== 7'b0) begin
      errs++; $display("FAIL sel_reset_data: got %b expected %b",
                       {tags(), busy}, 7'b0);
    end
    a_operational_out = 1;
    tick();
  endtask

  task automatic test_parity();
    connect(8'h01, 1'b1);
    checks++;
    if (parity_error !== 1'b1) begin
      errs++; $display("FAIL parity_set: got %b expected 1", parity_error);
    end
    a_operational_out = 0; tick();
    a_operational_out = 1; tick(); tick();
    checks++;
    if (parity_error !== 1'b1) begin
      errs++; $display("FAIL parity_sticky: got %b expected 1", parity_error);
    end
    aresetn = 0; tick();
    aresetn = 1; tick();
    checks++;
    if (parity_error !== 1'b0) begin
      errs++; $display("FAIL parity_clear: got %b expected 0", parity_error);
    end
  endtask

  task automatic test_reset_mid();
    connect(8'h01, 1'b0);
    wait_for(4, "mid_svc");
    a_service_out = 1; put_bus(8'h77, 1'b0);
    tick();
    a_service_out = 0; put_bus(8'h00, 1'b0);
    checks++;
    if (recv_tvalid !== 1'b1) begin
      errs++; $display("FAIL mid_pending: got %b expected 1", recv_tvalid);
    end
    aresetn = 0;
    #1;
    checks++;
    if ({recv_tvalid, busy, a_operational_in} !== 3'b000) begin
      errs++; $display("FAIL mid_async: got %b expected 000",
                       {recv_tvalid, busy, a_operational_in});
    end
    recv_tready = 1;
    tick(); tick();
    aresetn = 1;
    chan_idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({cmd_tvalid, recv_tvalid, send_tready, end_tready, busy} !== 5'b0) begin
        errs++; $display("FAIL mid_quiet: got %b expected %b",
          {cmd_tvalid, recv_tvalid, send_tready, end_tready, busy}, 5'b0);
      end
    end
    recv_tready = 0;
  endtask

  initial begin
    test_reset();
    test_select_cmd();
    test_no_select();
    test_write();
    test_read();
    test_stop();
    test_selective_reset();
    test_parity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
